interlaken_metaframe_framer: RTL and testbench



---
 rtl/interlaken_metaframe_framer.sv | 142 ++++++++++++++
 tb/tb_interlaken_metaframe_framer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/interlaken_metaframe_framer.sv
// Interlaken lane framer: wraps 64b/67b payload words into Sync/Scram/Skip/payload/Diag metaframes.
// One registered word per FRAME_ADVANCE. Payload is pulled only when a payload slot is emitted.
module interlaken_metaframe_framer #(
    parameter int unsigned METAFRAME_LEN = 2048,
    parameter logic [63:0] SYNC_WORD     = 64'h78f678f678f678f6,
    parameter logic [63:0] SKIP_WORD     = 64'h1e1e1e1e1e1e1e1e
) (
    input  logic        USER_CLK,
    input  logic        SYSTEM_RESET,
    input  logic        FRAME_ADVANCE,
    input  logic [63:0] DATA_IN,
    input  logic [1:0]  HEADER_IN,
    input  logic        DATA_IN_VALID,
    output logic        DATA_IN_READY,
    input  logic [1:0]  STATUS_IN,
    output logic [63:0] DATA_OUT,
    output logic [1:0]  HEADER_OUT,
    output logic        DATA_OUT_VALID
);

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_SCRAM,
        ST_SKIP,
        ST_PAYLOAD,
        ST_DIAG
    } state_t;

    localparam logic [1:0]  HDR_CTRL     = 2'b10;
    localparam logic [15:0] LAST_PAYLOAD = 16'(METAFRAME_LEN - 2);
    localparam logic [31:0] CRC_POLY     = 32'h1EDC6F41;
    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [63:0] data_q, data_d;
    logic [1:0]  hdr_q, hdr_d;
    logic        vld_q, vld_d;

    logic [63:0] word;
    logic [31:0] crc_upd;

    // CRC-32C, non-reflected, DATA_OUT[63] shifted in first.
    function automatic logic [31:0] crc32c_64(input logic [31:0] c, input logic [63:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 63; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
        end
        return r;
    endfunction

    assign DATA_IN_READY = FRAME_ADVANCE && (state_q == ST_PAYLOAD) && !SYSTEM_RESET;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        data_d  = data_q;
        hdr_d   = hdr_q;
        vld_d   = 1'b0;
        word    = 64'h0;
        crc_upd = crc_q;

        if (FRAME_ADVANCE) begin
            vld_d = 1'b1;
            hdr_d = HDR_CTRL;
            cnt_d = cnt_q + 16'd1;
            case (state_q)
                ST_SYNC: begin
                    word    = SYNC_WORD;
                    state_d = ST_SCRAM;
                end
                ST_SCRAM: begin
                    word    = {6'b001010, 58'h0};
                    state_d = ST_SKIP;
                end
                ST_SKIP: begin
                    word    = SKIP_WORD;
                    state_d = ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    if (DATA_IN_VALID) begin
                        word  = DATA_IN;
                        hdr_d = HEADER_IN;
                    end else begin
                        word  = SKIP_WORD;
                    end
                    if (cnt_q == LAST_PAYLOAD) begin
                        state_d = ST_DIAG;
                    end
                end
                ST_DIAG: begin
                    // CRC field is zero while it is being computed.
                    word    = {6'b011001, 24'h0, STATUS_IN, 32'h0};
                    state_d = ST_SYNC;
                    cnt_d   = 16'd0;
                end
                default: begin
                    word    = SYNC_WORD;
                    state_d = ST_SCRAM;
                    cnt_d   = 16'd1;
                end
            endcase

            crc_upd = crc32c_64(crc_q, word);
            if (state_q == ST_DIAG) begin
                data_d = {word[63:32], ~crc_upd};
                crc_d  = CRC_INIT;
            end else begin
                data_d = word;
                crc_d  = crc_upd;
            end
        end
    end

    always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            state_q <= ST_SYNC;
            cnt_q   <= 16'd0;
            crc_q   <= CRC_INIT;
            data_q  <= 64'h0;
            hdr_q   <= 2'b00;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            data_q  <= data_d;
            hdr_q   <= hdr_d;
            vld_q   <= vld_d;
        end
    end

    assign DATA_OUT       = data_q;
    assign HEADER_OUT     = hdr_q;
    assign DATA_OUT_VALID = vld_q;

endmodule

// File: tb/tb_interlaken_metaframe_framer.sv
// Directed vector bench for interlaken_metaframe_framer with an 8-word metaframe.
module tb_interlaken_metaframe_framer;

    localparam logic [63:0] SYNC_W = 64'h78f678f678f678f6;
    localparam logic [63:0] SKIP_W = 64'h1e1e1e1e1e1e1e1e;
    localparam logic [63:0] SCRM_W = {6'b001010, 58'h0};
    localparam logic [31:0] POLY   = 32'h1EDC6F41;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fa = 1'b0;
    logic [63:0] din = 64'h0;
    logic [1:0]  hin = 2'b00;
    logic        dvld = 1'b0;
    logic        drdy;
    logic [1:0]  st = 2'b00;
    logic [63:0] dout;
    logic [1:0]  hout;
    logic        ovld;

    always #5 clk = ~clk;

    interlaken_metaframe_framer #(
        .METAFRAME_LEN(8),
        .SYNC_WORD(SYNC_W),
        .SKIP_WORD(SKIP_W)
    ) dut (
        .USER_CLK(clk),
        .SYSTEM_RESET(rst),
        .FRAME_ADVANCE(fa),
        .DATA_IN(din),
        .HEADER_IN(hin),
        .DATA_IN_VALID(dvld),
        .DATA_IN_READY(drdy),
        .STATUS_IN(st),
        .DATA_OUT(dout),
        .HEADER_OUT(hout),
        .DATA_OUT_VALID(ovld)
    );

    typedef struct {
        logic        fa;
        logic        vld;
        logic [63:0] din;
        logic [1:0]  hin;
        logic [1:0]  st;
        logic        exp_rdy;
        logic        exp_vld;
        logic [63:0] exp_dat;
        logic [1:0]  exp_hdr;
        logic        is_diag;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] diag_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference model state used while building the table.
    logic [31:0] m_crc = 32'hFFFFFFFF;
    logic [63:0] m_dat = 64'h0;
    logic [1:0]  m_hdr = 2'b00;

    // Word-at-a-time formulation: xor a 32-bit chunk into the register, then 32 shifts.
    function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [63:0] d);
        logic [31:0] r;
        r = c;
        for (int h = 0; h < 2; h++) begin
            r = r ^ ((h == 0) ? d[63:32] : d[31:0]);
            for (int k = 0; k < 32; k++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
        end
        return r;
    endfunction

    task automatic push(input logic f, input logic v, input logic [63:0] di, input logic [1:0] hi,
                        input logic [1:0] s, input logic rdy, input logic ev, input logic diag);
        vec_t e;
        e.fa = f; e.vld = v; e.din = di; e.hin = hi; e.st = s;
        e.exp_rdy = rdy; e.exp_vld = ev; e.exp_dat = m_dat; e.exp_hdr = m_hdr; e.is_diag = diag;
        vecs.push_back(e);
    endtask

    task automatic add_frm(input logic [63:0] w, input logic ov, input logic [63:0] od);
        m_dat = w; m_hdr = 2'b10; m_crc = ref_crc(m_crc, w);
        push(1'b1, ov, od, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic add_pay(input logic v, input logic [63:0] d, input logic [1:0] h);
        m_dat = v ? d : SKIP_W; m_hdr = v ? h : 2'b10; m_crc = ref_crc(m_crc, m_dat);
        push(1'b1, v, d, h, 2'b00, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic add_diag(input logic [1:0] s);
        logic [63:0] w;
        w = {6'b011001, 24'h0, s, 32'h0};
        m_crc = ref_crc(m_crc, w);
        m_dat = {w[63:32], ~m_crc}; m_hdr = 2'b10; m_crc = 32'hFFFFFFFF;
        push(1'b1, 1'b0, 64'h0, 2'b00, s, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic add_idle(input logic v, input logic [63:0] d);
        push(1'b0, v, d, 2'b01, 2'b11, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic add_mf_a();
        add_frm(SYNC_W, 1'b1, 64'hDEAD);
        add_frm(SCRM_W, 1'b1, 64'hDEAD);
        add_frm(SKIP_W, 1'b1, 64'hDEAD);
        for (int i = 1; i <= 4; i++) add_pay(1'b1, 64'(i), 2'b01);
        add_diag(2'b00);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Entered at posedge+1; leaves at posedge+1 of the last output cycle.
    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) begin
            fa = vecs[i].fa; dvld = vecs[i].vld; din = vecs[i].din;
            hin = vecs[i].hin; st = vecs[i].st;
            #1;
            chk($sformatf("ready[%0d]", i), 64'(drdy), 64'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("valid[%0d]", i), 64'(ovld), 64'(vecs[i].exp_vld));
            chk($sformatf("data[%0d]", i), dout, vecs[i].exp_dat);
            chk($sformatf("hdr[%0d]", i), 64'(hout), 64'(vecs[i].exp_hdr));
            if (vecs[i].is_diag) diag_q.push_back(dout);
        end
        fa = 1'b0; dvld = 1'b0;
        vecs.delete();
    endtask

    initial begin
        // Reset held with FRAME_ADVANCE high: nothing may be emitted.
        fa = 1'b1; dvld = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(ovld), 64'h0);
        chk("rst_data", dout, 64'h0);
        chk("rst_hdr", 64'(hout), 64'h0);
        chk("rst_ready", 64'(drdy), 64'h0);
        fa = 1'b0; dvld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_valid", 64'(ovld), 64'h0);

        // A: basic metaframe. B: filler gaps, lane status. C: advance gaps, sync-like payload. D: repeat of A.
        add_mf_a();
        add_frm(SYNC_W, 1'b0, 64'h0);
        add_frm(SCRM_W, 1'b0, 64'h0);
        add_frm(SKIP_W, 1'b0, 64'h0);
        add_pay(1'b1, 64'h5, 2'b01);
        add_pay(1'b0, 64'hBAD0, 2'b01);
        add_pay(1'b0, 64'hBAD1, 2'b01);
        add_pay(1'b1, 64'h6, 2'b10);
        add_diag(2'b10);
        add_frm(SYNC_W, 1'b0, 64'h0);
        add_idle(1'b0, 64'h0);
        add_frm(SCRM_W, 1'b0, 64'h0);
        add_idle(1'b0, 64'h0);
        add_frm(SKIP_W, 1'b1, 64'h7);
        add_idle(1'b1, 64'h7);
        add_pay(1'b1, 64'h7, 2'b01);
        add_idle(1'b1, 64'h8);
        add_pay(1'b1, 64'h8, 2'b01);
        add_pay(1'b1, SYNC_W, 2'b10);
        add_idle(1'b1, 64'hA);
        add_pay(1'b1, 64'hA, 2'b01);
        add_diag(2'b01);
        add_idle(1'b0, 64'h0);
        add_mf_a();
        run_vecs();

        if (diag_q.size() == 4) begin
            chk("crc_repeat", diag_q[3], diag_q[0]);
            chk("diag_status", 64'(diag_q[1][33:32]), 64'h2);
            chk("diag_type", 64'(diag_q[1][63:58]), 64'h19);
            chk("diag_zero", 64'(diag_q[1][57:34]), 64'h0);
        end else begin
            chk("diag_count", 64'(diag_q.size()), 64'd4);
        end

        // Asynchronous reset mid-payload, then a fresh metaframe.
        add_frm(SYNC_W, 1'b0, 64'h0);
        add_frm(SCRM_W, 1'b0, 64'h0);
        add_frm(SKIP_W, 1'b0, 64'h0);
        add_pay(1'b1, 64'h11, 2'b01);
        run_vecs();
        fa = 1'b1; dvld = 1'b1; din = 64'h12; hin = 2'b01;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(ovld), 64'h0);
        chk("arst_data", dout, 64'h0);
        chk("arst_hdr", 64'(hout), 64'h0);
        chk("arst_ready", 64'(drdy), 64'h0);
        @(posedge clk);
        #1;
        chk("arst_hold_valid", 64'(ovld), 64'h0);
        chk("arst_hold_data", dout, 64'h0);
        fa = 1'b0; dvld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        m_crc = 32'hFFFFFFFF; m_dat = 64'h0; m_hdr = 2'b00;
        add_mf_a();
        run_vecs();
        if (diag_q.size() == 5) chk("crc_after_reset", diag_q[4], diag_q[0]);
        else chk("diag_count2", 64'(diag_q.size()), 64'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
